// File: rtl/cam_pkg.sv
// Shared encodings for the CAM command sequencer: opcodes, response error codes
// and the sequencer state enum.
package cam_pkg;

    localparam logic [1:0] OP_SEARCH = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_FLUSH  = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_FULL    = 2'd1;
    localparam logic [1:0] ERR_DUP     = 2'd2;
    localparam logic [1:0] ERR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational lowest-set-bit encoder over the masked CAM match vector.
// Index is 0 and found is 0 when the vector is empty.
module cam_prio_enc #(
    parameter  int ADDR_W = 4,
    localparam int DEPTH  = 2**ADDR_W
) (
    input  logic [DEPTH-1:0]  i_vec,
    output logic [ADDR_W-1:0] o_index,
    output logic              o_found
);

    // Scanning high-to-low lets the lowest set bit win the last assignment.
    function automatic logic [ADDR_W-1:0] lowest_idx(input logic [DEPTH-1:0] vec);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = ADDR_W'(i);
        end
        return idx;
    endfunction

    assign o_index = lowest_idx(i_vec);
    assign o_found = |i_vec;

endmodule

// File: rtl/cam_ctrl.sv
// cam_ctrl: search/insert/delete/flush sequencer for the bit-sliced CAM array.
// Define CAM_CTRL_DUP_CHECK_EN to look up the key before insert and reject duplicates.
module cam_ctrl
    import cam_pkg::*;
#(
    parameter  int KEY_W  = 4,
    parameter  int ADDR_W = 4,
    localparam int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [KEY_W-1:0]  cmd_key,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_index,
    output logic [DEPTH-1:0]  rsp_mask,
    output logic [1:0]        rsp_err,
    output logic              cam_rst,
    output logic              cam_write,
    output logic [ADDR_W-1:0] cam_addr,
    output logic [KEY_W-1:0]  cam_din,
    output logic [KEY_W-1:0]  cam_key,
    input  logic [DEPTH-1:0]  cam_match
);

    state_t              r_state;
    logic [1:0]          r_op;
    logic [KEY_W-1:0]    r_key;
    logic [DEPTH-1:0]    r_valid;
    logic [ADDR_W:0]     r_wptr;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic                r_rsp_hit;
    logic [ADDR_W-1:0]   r_rsp_index;
    logic [DEPTH-1:0]    r_rsp_mask;
    logic [1:0]          r_rsp_err;
    logic                r_cam_write;
    logic [ADDR_W-1:0]   r_cam_addr;
    logic [KEY_W-1:0]    r_cam_din;
    logic [KEY_W-1:0]    r_cam_key;

    logic                w_full;
    logic [ADDR_W-1:0]   w_slot;
    logic [DEPTH-1:0]    w_cap_mask;
    logic [ADDR_W-1:0]   w_cap_index;
    logic                w_cap_found;

    // wptr saturates at DEPTH, so its top bit alone flags a full array.
    assign w_full     = r_wptr[ADDR_W];
    assign w_slot     = r_wptr[ADDR_W-1:0];
    assign w_cap_mask = cam_match & r_valid;

    cam_prio_enc #(.ADDR_W(ADDR_W)) u_prio_enc (
        .i_vec   (w_cap_mask),
        .o_index (w_cap_index),
        .o_found (w_cap_found)
    );

    // Sequencer: one command in flight; every output is loaded on a state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_SEARCH;
            r_key       <= '0;
            r_valid     <= '0;
            r_wptr      <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_index <= '0;
            r_rsp_mask  <= '0;
            r_rsp_err   <= ERR_OK;
            r_cam_write <= 1'b0;
            r_cam_addr  <= '0;
            r_cam_din   <= '0;
            r_cam_key   <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_cam_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_op        <= cmd_op;
                        r_key       <= cmd_key;
                        r_cmd_ready <= 1'b0;
                        case (cmd_op)
                            OP_SEARCH: begin
                                r_cam_key <= cmd_key;
                                r_state   <= ST_LOOKUP;
                            end
                            OP_INSERT: begin
`ifdef CAM_CTRL_DUP_CHECK_EN
                                r_cam_key <= cmd_key;
                                r_state   <= ST_LOOKUP;
`else
                                if (!w_full) begin
                                    r_cam_write <= 1'b1;
                                    r_cam_addr  <= w_slot;
                                    r_cam_din   <= cmd_key;
                                end
                                r_state <= ST_WRITE;
`endif
                            end
                            OP_DELETE: begin
                                r_valid[cmd_addr] <= 1'b0;
                                r_rsp_valid       <= 1'b1;
                                r_rsp_hit         <= 1'b0;
                                r_rsp_index       <= '0;
                                r_rsp_mask        <= '0;
                                r_rsp_err         <= r_valid[cmd_addr] ? ERR_OK : ERR_INVALID;
                                r_state           <= ST_RESP;
                            end
                            OP_FLUSH: r_state <= ST_FLUSH;
                            default: begin
                                r_cmd_ready <= 1'b1;
                                r_state     <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_LOOKUP: r_state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    if ((r_op == OP_INSERT) && w_cap_found) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_hit   <= 1'b1;
                        r_rsp_index <= w_cap_index;
                        r_rsp_mask  <= w_cap_mask;
                        r_rsp_err   <= ERR_DUP;
                        r_state     <= ST_RESP;
                    end else if (r_op == OP_INSERT) begin
                        if (!w_full) begin
                            r_cam_write <= 1'b1;
                            r_cam_addr  <= w_slot;
                            r_cam_din   <= r_key;
                        end
                        r_state <= ST_WRITE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_hit   <= w_cap_found;
                        r_rsp_index <= w_cap_index;
                        r_rsp_mask  <= w_cap_mask;
                        r_rsp_err   <= ERR_OK;
                        r_state     <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_hit   <= 1'b0;
                    r_rsp_mask  <= '0;
                    if (w_full) begin
                        r_rsp_index <= '0;
                        r_rsp_err   <= ERR_FULL;
                    end else begin
                        r_valid[w_slot] <= 1'b1;
                        r_rsp_index     <= w_slot;
                        r_rsp_err       <= ERR_OK;
                        r_wptr          <= r_wptr + {{ADDR_W{1'b0}}, 1'b1};
                    end
                    r_state <= ST_RESP;
                end
                ST_FLUSH: begin
                    r_valid     <= '0;
                    r_wptr      <= '0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_hit   <= 1'b0;
                    r_rsp_index <= '0;
                    r_rsp_mask  <= '0;
                    r_rsp_err   <= ERR_OK;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Array clear follows system reset as well as the one-cycle flush state.
    assign cam_rst   = ~rst_n | (r_state == ST_FLUSH);
    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_index = r_rsp_index;
    assign rsp_mask  = r_rsp_mask;
    assign rsp_err   = r_rsp_err;
    assign cam_write = r_cam_write;
    assign cam_addr  = r_cam_addr;
    assign cam_din   = r_cam_din;
    assign cam_key   = r_cam_key;

endmodule

// File: tb/tb_cam_ctrl.sv
// Scoreboard bench for cam_ctrl with a behavioural CAM array (falling-edge match register).
// Expectations honour CAM_CTRL_DUP_CHECK_EN when it is defined for the build.
module tb_cam_ctrl;
    import cam_pkg::*;

    localparam int KEY_W  = 4;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
`ifdef CAM_CTRL_DUP_CHECK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [KEY_W-1:0]  cmd_key;
    logic [ADDR_W-1:0] cmd_addr;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [ADDR_W-1:0] rsp_index;
    logic [DEPTH-1:0]  rsp_mask;
    logic [1:0]        rsp_err;
    logic              cam_rst;
    logic              cam_write;
    logic [ADDR_W-1:0] cam_addr;
    logic [KEY_W-1:0]  cam_din;
    logic [KEY_W-1:0]  cam_key;
    logic [DEPTH-1:0]  cam_match;

    cam_ctrl #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_key   (cmd_key),
        .cmd_addr  (cmd_addr),
        .rsp_valid (rsp_valid),
        .rsp_hit   (rsp_hit),
        .rsp_index (rsp_index),
        .rsp_mask  (rsp_mask),
        .rsp_err   (rsp_err),
        .cam_rst   (cam_rst),
        .cam_write (cam_write),
        .cam_addr  (cam_addr),
        .cam_din   (cam_din),
        .cam_key   (cam_key),
        .cam_match (cam_match)
    );

    always #5 clk = ~clk;

    // Behavioural CAM: synchronous write/clear, match registered on the falling edge.
    logic [KEY_W-1:0] cam_mem [DEPTH];
    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (cam_rst) cam_mem[i] <= '0;
            else if (cam_write && (int'(cam_addr) == i)) cam_mem[i] <= cam_din;
        end
    end
    always @(negedge clk) begin
        for (int i = 0; i < DEPTH; i++) cam_match[i] <= (cam_mem[i] == cam_key);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic              hit;
        logic [ADDR_W-1:0] idx;
        logic [DEPTH-1:0]  mask;
        logic [1:0]        err;
        int                due;
    } exp_t;

    exp_t             sb_q[$];
    logic [KEY_W-1:0] m_key [DEPTH];
    logic [DEPTH-1:0] m_vld;
    int               m_wptr;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               wr_cnt  = 0;
    int               rst_cnt = 0;
    int               overlap = 0;
    int               snap;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DEPTH-1:0] ref_mask(input logic [KEY_W-1:0] key);
        logic [DEPTH-1:0] m;
        m = '0;
        for (int i = 0; i < DEPTH; i++) m[i] = m_vld[i] && (m_key[i] == key);
        return m;
    endfunction

    function automatic logic [ADDR_W-1:0] ref_low(input logic [DEPTH-1:0] v);
        for (int i = 0; i < DEPTH; i++) begin
            if (v[i]) return ADDR_W'(i);
        end
        return '0;
    endfunction

    // Reference model: updates shadow state and queues the expected response.
    task automatic model_push(input logic [1:0] op, input logic [KEY_W-1:0] key,
                              input logic [ADDR_W-1:0] addr);
        exp_t e;
        int   lat;
        e.hit = 1'b0; e.idx = '0; e.mask = '0; e.err = ERR_OK;
        case (op)
            OP_SEARCH: begin
                lat    = 3;
                e.mask = ref_mask(key);
                e.hit  = |e.mask;
                e.idx  = ref_low(e.mask);
            end
            OP_INSERT: begin
                lat = DUP ? 4 : 2;
                if (DUP && (ref_mask(key) != '0)) begin
                    e.mask = ref_mask(key);
                    e.hit  = 1'b1;
                    e.idx  = ref_low(e.mask);
                    e.err  = ERR_DUP;
                end else if (m_wptr >= DEPTH) begin
                    e.err = ERR_FULL;
                end else begin
                    e.idx          = ADDR_W'(m_wptr);
                    m_key[m_wptr]  = key;
                    m_vld[m_wptr]  = 1'b1;
                    m_wptr++;
                end
            end
            OP_DELETE: begin
                lat = 1;
                if (m_vld[addr]) m_vld[addr] = 1'b0;
                else e.err = ERR_INVALID;
            end
            default: begin
                lat    = 2;
                m_vld  = '0;
                m_wptr = 0;
            end
        endcase
        e.due = cyc + 1 + lat;
        sb_q.push_back(e);
    endtask

    // Advance to the next falling edge and run the output monitors there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("rsp_spurious", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("rsp_cycle", 32'(cyc + 1), 32'(e.due));
                check_eq("rsp_hit",   32'(rsp_hit),   32'(e.hit));
                check_eq("rsp_index", 32'(rsp_index), 32'(e.idx));
                check_eq("rsp_mask",  32'(rsp_mask),  32'(e.mask));
                check_eq("rsp_err",   32'(rsp_err),   32'(e.err));
            end
        end
        if (cam_write) begin
            wr_cnt++;
            check_eq("cam_din", 32'(cam_din), 32'(m_key[cam_addr]));
            if (cam_rst) overlap++;
        end
        if (rst_n && cam_rst) rst_cnt++;
    endtask

    task automatic wait_ready();
        for (int g = 0; g < 20 && !cmd_ready; g++) tick();
        if (!cmd_ready) check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [KEY_W-1:0] key,
                          input logic [ADDR_W-1:0] addr);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        cmd_addr  = addr;
        model_push(op, key, addr);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int g = 0; g < 20 && sb_q.size() != 0; g++) tick();
        if (sb_q.size() != 0) check_eq("rsp_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_addr = '0;
        m_vld = '0; m_wptr = 0;
        for (int i = 0; i < DEPTH; i++) m_key[i] = '0;
        tick(); tick(); tick();
        check_eq("cam_rst_in_reset", 32'(cam_rst), 32'd1);
        rst_n = 1'b1;
        #1;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_bus", {rsp_mask, 8'(rsp_index), 6'(rsp_err), 2'(rsp_hit)}, 32'd0);
        check_eq("rst_cam_bus", {cam_write, 3'(cam_addr), 4'(cam_din), 4'(cam_key), 20'd0}, 32'd0);
        check_eq("rst_cam_rst", 32'(cam_rst), 32'd0);

        // Two inserts then a search of the second key.
        do_cmd(OP_INSERT, 4'h5, 4'h0);
        do_cmd(OP_INSERT, 4'hA, 4'h0);
        do_cmd(OP_SEARCH, 4'hA, 4'h0);
        drain();

        // Duplicate keys, delete masking stale entries, delete of an invalid slot.
        do_cmd(OP_FLUSH,  4'h0, 4'h0);
        do_cmd(OP_INSERT, 4'h3, 4'h0);
        do_cmd(OP_INSERT, 4'h7, 4'h0);
        do_cmd(OP_INSERT, 4'h3, 4'h0);
        do_cmd(OP_SEARCH, 4'h3, 4'h0);
        do_cmd(OP_DELETE, 4'h0, 4'h0);
        do_cmd(OP_SEARCH, 4'h3, 4'h0);
        do_cmd(OP_DELETE, 4'h0, 4'h0);
        do_cmd(OP_DELETE, 4'h0, 4'h1);
        do_cmd(OP_SEARCH, 4'h7, 4'h0);
        drain();

        // Fill the array; a freed slot is not reused, so the next insert is full.
        do_cmd(OP_FLUSH, 4'h0, 4'h0);
        for (int i = 0; i < DEPTH; i++) do_cmd(OP_INSERT, 4'(i), 4'h0);
        do_cmd(OP_DELETE, 4'h0, 4'h3);
        drain();
        snap = wr_cnt;
        do_cmd(OP_INSERT, 4'h3, 4'h0);
        drain();
        check_eq("full_no_write", 32'(wr_cnt), 32'(snap));
        snap = rst_cnt;
        do_cmd(OP_FLUSH, 4'h0, 4'h0);
        drain();
        check_eq("flush_rst_width", 32'(rst_cnt - snap), 32'd1);
        do_cmd(OP_SEARCH, 4'h0, 4'h0);
        do_cmd(OP_SEARCH, 4'hC, 4'h0);
        do_cmd(OP_INSERT, 4'hB, 4'h0);
        drain();

        // Same key twice.
        do_cmd(OP_FLUSH,  4'h0, 4'h0);
        do_cmd(OP_INSERT, 4'h9, 4'h0);
        do_cmd(OP_INSERT, 4'h9, 4'h0);
        do_cmd(OP_INSERT, 4'h1, 4'h0);
        drain();

        // Reset while a search sits in CAPTURE.
        do_cmd(OP_FLUSH,  4'h0, 4'h0);
        do_cmd(OP_INSERT, 4'h6, 4'h0);
        drain();
        wait_ready();
        cmd_valid = 1'b1; cmd_op = OP_SEARCH; cmd_key = 4'h6;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_cam_rst",   32'(cam_rst),   32'd1);
        check_eq("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick(); tick();
        m_vld = '0; m_wptr = 0;
        rst_n = 1'b1;
        tick(); tick(); tick();
        do_cmd(OP_SEARCH, 4'h6, 4'h0);
        do_cmd(OP_INSERT, 4'h2, 4'h0);
        drain();

        check_eq("write_rst_overlap", 32'(overlap), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
